// File: rtl/pkt_framer_pkg.sv
// Shared types and helpers for the packet framer.
// Contents: FSM state enum, header field constants, even-parity helper.
package pkt_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Sequence number occupies the top SEQ_W header bits; command sits at bit 0,
    // master id directly above the command.
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned CMD_LSB = 0;

    // Widest field concatenation the parity helper accepts; callers zero-extend.
    localparam int unsigned PAR_MAX_W = 512;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/pkt_framer_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot), idx (granted index), any (some request present).
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned cand;

    // Scan from ptr upward with wrap; first requester found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pkt_framer.sv
// Packet framer: round-robin arbitrates N masters, frames header with an
// 8-bit sequence number, adds even parity, drives a valid/ack bus and retries
// on ack timeout, dropping the packet (err_valid pulse) after MAX_RETRY retries.
// Ports: req_valid/req_cmd/req_payload in, req_ready one-hot grant pulse out;
//        out_* framed packet bus with out_ack in; err_valid/err_master_id on drop.
module pkt_framer
    import pkt_framer_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 4,
    parameter  int unsigned PAYLOAD_W   = 16,
    parameter  int unsigned CMD_W       = 4,
    parameter  int unsigned HDR_W       = 32,
    parameter  int unsigned ACK_TIMEOUT = 15,
    parameter  int unsigned MAX_RETRY   = 3,
    localparam int unsigned MID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_valid,
    input  logic [NUM_MASTERS*CMD_W-1:0]   req_cmd,
    input  logic [NUM_MASTERS*PAYLOAD_W-1:0] req_payload,
    output logic [NUM_MASTERS-1:0]         req_ready,
    output logic                           out_valid,
    output logic [HDR_W-1:0]               out_header,
    output logic [PAYLOAD_W-1:0]           out_payload,
    output logic [CMD_W-1:0]               out_command,
    output logic [MID_W-1:0]               out_master_id,
    output logic                           out_parity,
    input  logic                           out_ack,
    output logic                           err_valid,
    output logic [MID_W-1:0]               err_master_id
);

    localparam int unsigned WAIT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e               state_q, state_d;
    logic [MID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [HDR_W-1:0]     out_header_q, out_header_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic [CMD_W-1:0]     out_command_q, out_command_d;
    logic [MID_W-1:0]     out_master_id_q, out_master_id_d;
    logic                 out_parity_q, out_parity_d;
    logic                 err_valid_q, err_valid_d;
    logic [MID_W-1:0]     err_master_id_q, err_master_id_d;

    logic [NUM_MASTERS-1:0] gnt;
    logic [MID_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic [CMD_W-1:0]       cmd_sel;
    logic [PAYLOAD_W-1:0]   pay_sel;
    logic [HDR_W-1:0]       hdr_new;
    logic                   par_new;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grant is a same-cycle consume pulse, so it is combinational from the request.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    assign cmd_sel = req_cmd[32'(gnt_idx) * CMD_W +: CMD_W];
    assign pay_sel = req_payload[32'(gnt_idx) * PAYLOAD_W +: PAYLOAD_W];

    // Header for the packet being granted now; unused bits stay zero.
    always_comb begin
        hdr_new                             = '0;
        hdr_new[HDR_W-1 -: SEQ_W]           = seq_q;
        hdr_new[CMD_W +: MID_W]             = gnt_idx;
        hdr_new[CMD_LSB +: CMD_W]           = cmd_sel;
    end

    assign par_new = parity(PAR_MAX_W'({hdr_new, pay_sel, cmd_sel, gnt_idx}));

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        seq_d           = seq_q;
        wait_cnt_d      = wait_cnt_q;
        retry_cnt_d     = retry_cnt_q;
        out_valid_d     = out_valid_q;
        out_header_d    = out_header_q;
        out_payload_d   = out_payload_q;
        out_command_d   = out_command_q;
        out_master_id_d = out_master_id_q;
        out_parity_d    = out_parity_q;
        err_valid_d     = 1'b0;
        err_master_id_d = err_master_id_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (gnt_any) begin
                    out_header_d    = hdr_new;
                    out_payload_d   = pay_sel;
                    out_command_d   = cmd_sel;
                    out_master_id_d = gnt_idx;
                    out_parity_d    = par_new;
                    wait_cnt_d      = '0;
                    retry_cnt_d     = '0;
                    rr_ptr_d        = MID_W'((32'(gnt_idx) + 1) % NUM_MASTERS);
                    out_valid_d     = 1'b1;
                    state_d         = SEND;
                end
            end
            SEND: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (out_ack) begin
                    seq_d       = SEQ_W'(seq_q + 1'b1);
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (wait_cnt_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    out_valid_d = 1'b0;
                    if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_d = RETRY_W'(retry_cnt_q + 1'b1);
                        state_d     = GAP;
                    end else begin
                        err_valid_d     = 1'b1;
                        err_master_id_d = out_master_id_q;
                        state_d         = IDLE;
                    end
                end else begin
                    wait_cnt_d = WAIT_W'(wait_cnt_q + 1'b1);
                end
            end
            GAP: begin
                wait_cnt_d  = '0;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            seq_q           <= '0;
            wait_cnt_q      <= '0;
            retry_cnt_q     <= '0;
            out_valid_q     <= 1'b0;
            out_header_q    <= '0;
            out_payload_q   <= '0;
            out_command_q   <= '0;
            out_master_id_q <= '0;
            out_parity_q    <= 1'b0;
            err_valid_q     <= 1'b0;
            err_master_id_q <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            seq_q           <= seq_d;
            wait_cnt_q      <= wait_cnt_d;
            retry_cnt_q     <= retry_cnt_d;
            out_valid_q     <= out_valid_d;
            out_header_q    <= out_header_d;
            out_payload_q   <= out_payload_d;
            out_command_q   <= out_command_d;
            out_master_id_q <= out_master_id_d;
            out_parity_q    <= out_parity_d;
            err_valid_q     <= err_valid_d;
            err_master_id_q <= err_master_id_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_header    = out_header_q;
    assign out_payload   = out_payload_q;
    assign out_command   = out_command_q;
    assign out_master_id = out_master_id_q;
    assign out_parity    = out_parity_q;
    assign err_valid     = err_valid_q;
    assign err_master_id = err_master_id_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer: stimulus pushes expected packets / drops,
// a negedge monitor pops and compares on each out_valid rising edge and err_valid.
module tb_pkt_framer;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned HW = 32;
    localparam int unsigned TO = 15;
    localparam int unsigned MR = 3;
    localparam int unsigned MW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N*PW-1:0] req_payload;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [HW-1:0]   out_header;
    logic [PW-1:0]   out_payload;
    logic [CW-1:0]   out_command;
    logic [MW-1:0]   out_master_id;
    logic            out_parity;
    logic            out_ack;
    logic            err_valid;
    logic [MW-1:0]   err_master_id;

    always #5 clk = ~clk;

    pkt_framer #(
        .NUM_MASTERS(N), .PAYLOAD_W(PW), .CMD_W(CW), .HDR_W(HW),
        .ACK_TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_payload(req_payload),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_header(out_header), .out_payload(out_payload),
        .out_command(out_command), .out_master_id(out_master_id),
        .out_parity(out_parity), .out_ack(out_ack),
        .err_valid(err_valid), .err_master_id(err_master_id)
    );

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [PW-1:0] pl;
        logic [CW-1:0] cmd;
        logic [MW-1:0] mid;
        logic          par;
    } pkt_t;

    pkt_t        exp_q[$];
    logic [MW-1:0] err_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_seq = 8'h00;

    function automatic pkt_t mk(input logic [7:0] s, input int m,
                                input logic [CW-1:0] c, input logic [PW-1:0] p);
        pkt_t k;
        k.hdr = {s, 18'h0, MW'(m), c};
        k.pl  = p;
        k.cmd = c;
        k.mid = MW'(m);
        k.par = ^{k.hdr, k.pl, k.cmd, k.mid};
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected packet per SEND window, one expected entry per drop.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        pkt_t e;
        logic [MW-1:0] em;
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pkt", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_header", out_header, e.hdr);
                check("sb_payload", out_payload, e.pl);
                check("sb_command", out_command, e.cmd);
                check("sb_master_id", out_master_id, e.mid);
                check("sb_parity", out_parity, e.par);
            end
        end
        if (err_valid) begin
            if (err_q.size() == 0) begin
                check("unexpected_err", 1, 0);
            end else begin
                em = err_q.pop_front();
                check("sb_err_master_id", err_master_id, em);
            end
        end
        prev_valid = out_valid;
    end

    // Request master m (called at a negedge); returns at the first SEND negedge.
    task automatic grant(input int m, input logic [CW-1:0] c, input logic [PW-1:0] p,
                         input int nwin);
        int w;
        req_cmd[m*CW +: CW]     = c;
        req_payload[m*PW +: PW] = p;
        req_valid[m]            = 1'b1;
        w = 0;
        #1;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("grant_onehot", req_ready, 64'(1) << m);
        for (int i = 0; i < nwin; i++) exp_q.push_back(mk(exp_seq, m, c, p));
        @(negedge clk);
        req_valid[m] = 1'b0;
        #1;
        check("grant_pulse", req_ready, 0);
        check("grant_valid_next", out_valid, 1);
    endtask

    task automatic ack_now();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_seq = 8'h00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int w;
        rst = 1'b1; req_valid = '0; req_cmd = '0; req_payload = '0; out_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        // Reset state; requests must not be granted while reset is held.
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_header", out_header, 0);
        check("rst_payload", out_payload, 0);
        check("rst_parity", out_parity, 0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request, immediate ack.
        grant(2, 4'h5, 16'hBEEF, 1);
        check("t1_header", out_header, 32'h0000_0025);
        check("t1_parity", out_parity, 1);
        ack_now();
        check("t1_valid_low", out_valid, 0);
        @(negedge clk);
        check("t1_valid_one_cycle", out_valid, 0);
        grant(0, 4'h1, 16'h0000, 1);
        check("t1_seq_incr_hdr", out_header, 32'h0100_0001);
        ack_now();

        // Round-robin from reset pointer with all masters requesting.
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_cmd[k*CW +: CW]     = CW'(k + 8);
            req_payload[k*PW +: PW] = PW'(16'hA000 + k);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            m = k % 4;
            w = 0;
            #1;
            while (req_ready == '0 && w < 10) begin
                @(negedge clk); #1; w++;
            end
            check("rr_grant", req_ready, 64'(1) << m);
            exp_q.push_back(mk(exp_seq, m, CW'(m + 8), PW'(16'hA000 + m)));
            @(negedge clk);
            if (k == 4) req_valid = '0;
            #1;
            check("rr_pulse", req_ready, 0);
            check("rr_valid", out_valid, 1);
            ack_now();
        end
        @(negedge clk);

        // Timeout and retry, ack in the second SEND window.
        grant(1, 4'h3, 16'h1234, 2);
        count_high(n);
        check("retry_win1_len", n, TO);
        check("retry_gap_no_err", err_valid, 0);
        @(negedge clk);
        check("retry_resend", out_valid, 1);
        @(negedge clk); @(negedge clk);
        ack_now();
        check("retry_ack_low", out_valid, 0);
        @(negedge clk);

        // Drop after MAX_RETRY retries.
        grant(3, 4'hA, 16'hCAFE, MR + 1);
        err_q.push_back(MW'(3));
        for (int win = 0; win <= MR; win++) begin
            count_high(n);
            check("drop_win_len", n, TO);
            if (win < MR) begin
                check("drop_gap_no_err", err_valid, 0);
                @(negedge clk);
            end else begin
                check("drop_err_pulse", err_valid, 1);
                check("drop_err_mid", err_master_id, 3);
            end
        end
        @(negedge clk);
        check("drop_err_one_cycle", err_valid, 0);
        check("drop_no_resend", out_valid, 0);

        // Ack coincident with timeout expiry: ack wins, no GAP/resend.
        grant(0, 4'h7, 16'h0F0F, 1);
        repeat (TO - 1) @(negedge clk);
        check("coinc_still_valid", out_valid, 1);
        ack_now();
        check("coinc_low", out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("coinc_no_resend", out_valid, 0);
        end

        // Reset mid-SEND.
        grant(1, 4'h2, 16'h5555, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_header", out_header, 0);
        check("mrst_payload", out_payload, 0);
        check("mrst_command", out_command, 0);
        check("mrst_mid", out_master_id, 0);
        check("mrst_parity", out_parity, 0);
        check("mrst_err", err_valid, 0);
        rst = 1'b0;
        exp_seq = 8'h00;
        @(negedge clk);
        check("mrst_err_after", err_valid, 0);
        req_cmd[0 +: CW] = 4'h4; req_payload[0 +: PW] = 16'h0001;
        req_cmd[2*CW +: CW] = 4'h6; req_payload[2*PW +: PW] = 16'h0002;
        req_valid = 4'b0101;
        #1;
        check("mrst_rr_ptr0", req_ready, 4'b0001);
        exp_q.push_back(mk(exp_seq, 0, 4'h4, 16'h0001));
        @(negedge clk);
        req_valid = '0;
        ack_now();

        // Sequence wrap: 256 acked packets from reset bring seq back to 0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            grant(i % 4, CW'(i), PW'(i), 1);
            ack_now();
        end
        grant(1, 4'hF, 16'hFFFF, 1);
        check("wrap_seq_zero", out_header[31:24], 8'h00);
        ack_now();

        repeat (3) @(negedge clk);
        check("sb_pkt_queue_empty", exp_q.size(), 0);
        check("sb_err_queue_empty", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
